// File: rtl/ov7670_capture_qqvga.sv
// OV7670 RGB565 capture: assembles byte pairs into pixels, decimates 4x in both axes
// and writes the result into a 160x120 frame buffer with per-frame done/error status.
module ov7670_capture_qqvga #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int SRC_W = 640,
  parameter int SRC_H = 480
) (
  input  logic        CLK25,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [14:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_en,
  output logic        frame_done,
  output logic        frame_err
);

  localparam logic [9:0]  SRC_W_L   = 10'(SRC_W);
  localparam logic [8:0]  SRC_H_L   = 9'(SRC_H);
  localparam logic [14:0] IMG_W_L   = 15'(IMG_W);
  localparam logic [14:0] FRAME_PIX = 15'(IMG_W * IMG_H);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DONE} state_e;

  state_e      state_q;
  logic        vsync_q, vsync_prev_q, href_q, href_prev_q;
  logic [7:0]  data_q, hi_q;
  logic        phase_q, line_pix_q, overrun_q;
  logic [9:0]  hcnt_q;
  logic [8:0]  vcnt_q;
  logic [14:0] wr_count_q;
  logic [14:0] wr_addr_q;
  logic [15:0] wr_data_q;
  logic        wr_en_q, frame_done_q, frame_err_q;

  logic        vsync_fall, vsync_rise, href_fall;
  logic        in_range, pix_write;
  logic [14:0] addr_d;

  // Camera pins share CLK25, so one register stage is enough; edges compare it with its previous value.
  always_ff @(posedge CLK25 or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_q       <= 1'b0;
      href_prev_q  <= 1'b0;
      data_q       <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the pre-edge values,
      // so the *_prev_q copies really hold last cycle's value regardless of statement order.
      vsync_q      <= cam_vsync;
      vsync_prev_q <= vsync_q;
      href_q       <= cam_href;
      href_prev_q  <= href_q;
      data_q       <= cam_data;
    end
  end

  always_comb begin
    vsync_fall = vsync_prev_q & ~vsync_q;
    vsync_rise = ~vsync_prev_q & vsync_q;
    href_fall  = href_prev_q & ~href_q;
    in_range   = (hcnt_q < SRC_W_L) && (vcnt_q < SRC_H_L);
    pix_write  = in_range && (hcnt_q[1:0] == 2'b00) && (vcnt_q[1:0] == 2'b00);
    addr_d     = 15'(vcnt_q[8:2]) * IMG_W_L + 15'(hcnt_q[9:2]);
  end

  always_ff @(posedge CLK25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hi_q         <= 8'd0;
      phase_q      <= 1'b0;
      line_pix_q   <= 1'b0;
      overrun_q    <= 1'b0;
      hcnt_q       <= 10'd0;
      vcnt_q       <= 9'd0;
      wr_count_q   <= 15'd0;
      wr_addr_q    <= 15'd0;
      wr_data_q    <= 16'd0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) state_q <= WAIT_SOF;
        end
        WAIT_SOF: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (vsync_fall) begin
            state_q    <= ACTIVE;
            hcnt_q     <= 10'd0;
            vcnt_q     <= 9'd0;
            phase_q    <= 1'b0;
            line_pix_q <= 1'b0;
            wr_count_q <= 15'd0;
            overrun_q  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (href_q) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
              hi_q <= data_q;
            end else begin
              line_pix_q <= 1'b1;
              if (hcnt_q != SRC_W_L) hcnt_q <= hcnt_q + 10'd1;
              if (!in_range) overrun_q <= 1'b1;
              if (pix_write) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_d;
                wr_data_q <= {hi_q, data_q};
                if (wr_count_q != '1) wr_count_q <= wr_count_q + 15'd1;
              end
            end
          end else if (href_fall) begin
            // A dangling high byte is dropped; lines with no complete pixel do not advance vcnt.
            phase_q    <= 1'b0;
            hcnt_q     <= 10'd0;
            line_pix_q <= 1'b0;
            if (line_pix_q && (vcnt_q != SRC_H_L)) vcnt_q <= vcnt_q + 9'd1;
          end
          if (vsync_rise) state_q <= DONE;
        end
        DONE: begin
          frame_done_q <= 1'b1;
          frame_err_q  <= overrun_q | (wr_count_q != FRAME_PIX);
          state_q      <= enable ? WAIT_SOF : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule
